instr_fetch_ctrl: RTL and testbench

- Sequences the instruction ROM: owns the program counter, drives the ROM byte address, and captures the 32-bit little-endian word returned.
- Buffers fetched words with their PCs in a small FIFO toward decode, using a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and reloading the PC.
- Sits between the instruction ROM (combinational read, byte-addressed, 256-byte array) and the decode stage.

---
 rtl/instr_fetch_ctrl_if.sv | 27 ++
 rtl/instr_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - ROM read bus and decode-side valid/ready stream of the fetch controller
interface instr_fetch_ctrl_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output rom_addr,
    input  rom_dout,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  rom_addr,
    output rom_dout,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - PC sequencer, ROM fetch and PC/word FIFO toward decode with redirect flush
// Optional performance counters are built when FETCH_PERF_EN is defined.
module instr_fetch_ctrl #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          ROM_BYTES  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  instr_fetch_ctrl_if.master bus,
  output logic              fetch_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [15:0]       perf_flush
`endif
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      PC_LIMIT = 32'(ROM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           state, state_next;
  logic [31:0]      fetch_pc, fetch_pc_next;
  logic [31:0]      mem_pc    [FIFO_DEPTH];
  logic [31:0]      mem_instr [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      last_pc, last_instr;
  logic             full, empty, pop, push, flush, err_set;
  logic             want_push, misaligned, out_of_range;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign pop   = !empty && bus.out_ready;

  assign bus.rom_addr  = fetch_pc;
  assign bus.out_valid = !empty;
  assign bus.out_instr = empty ? last_instr : mem_instr[rd_ptr];
  assign bus.out_pc    = empty ? last_pc    : mem_pc[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= PC_RESET;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    flush         = 1'b0;
    err_set       = 1'b0;
    want_push     = (state == RUN) && !redirect_valid && (!full || pop);
    misaligned    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    out_of_range  = want_push && (fetch_pc > PC_LIMIT);

    case (state)
      IDLE:    if (fetch_en)  state_next = RUN;
      RUN:     if (!fetch_en) state_next = IDLE;
      default: state_next = HALT;
    endcase

    // Errors win over redirect, which wins over push; HALT ignores everything.
    if (state != HALT) begin
      if (misaligned || out_of_range) begin
        state_next = HALT;
        err_set    = 1'b1;
        flush      = 1'b1;
      end else if (redirect_valid) begin
        flush         = 1'b1;
        fetch_pc_next = redirect_pc;
      end else if (want_push) begin
        push          = 1'b1;
        fetch_pc_next = fetch_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_pc    <= '0;
      last_instr <= '0;
      fetch_err  <= 1'b0;
    end else begin
      if (err_set) fetch_err <= 1'b1;
      if (pop) begin
        last_pc    <= mem_pc[rd_ptr];
        last_instr <= mem_instr[rd_ptr];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= fetch_pc;
      mem_instr[wr_ptr] <= bus.rom_dout;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else if (state != HALT) begin
      if (push && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if ((state == RUN) && full && !pop && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
      if (redirect_valid && (perf_flush != '1)) perf_flush <= perf_flush + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed vector bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
  logic [15:0] perf_flush;
`endif

  always #5 clk = ~clk;

  instr_fetch_ctrl_if bus ();

  logic [7:0] rom [256];
  logic [7:0] a0, a1, a2, a3;
  assign a0 = bus.rom_addr[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;
  assign bus.rom_dout = {rom[a3], rom[a2], rom[a1], rom[a0]};

  instr_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fetch_err      (fetch_err)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  typedef struct {
    bit          rst;
    bit          fe;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
    bit          eerr;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t v(bit rst, bit fe, bit rdy, bit rv, logic [31:0] rpc,
                             bit ev, logic [31:0] epc, logic [31:0] ei,
                             logic [31:0] ea, bit eerr);
    vec_t r;
    r.rst = rst; r.fe = fe; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
    r.ev = ev; r.epc = epc; r.einstr = ei; r.eaddr = ea; r.eerr = eerr;
    return r;
  endfunction

  function automatic logic [31:0] word_at(logic [31:0] p);
    logic [7:0] b;
    b = p[7:0];
    return {rom[b + 8'd3], rom[b + 8'd2], rom[b + 8'd1], rom[b]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] hdr [16];
    hdr = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
            8'h13, 8'h06, 8'h30, 8'h00, 8'h33, 8'h07, 8'hB5, 8'h00};
    for (int i = 0; i < 256; i++) rom[i] = i[7:0];
    for (int i = 0; i < 16; i++) rom[i] = hdr[i];
    bus.out_ready = 1'b0;

    // streaming with decode always ready
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 0, 32'h00, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 32'h00, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h00, 32'h00100513, 32'h04, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h04, 32'h00200593, 32'h08, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h08, 32'h00300613, 32'h0C, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h0C, 32'h00B50733, 32'h10, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h10, 32'h13121110, 32'h14, 0));
    // back-pressure for five cycles, then drain without gaps
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 32'h00, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 32'h00, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h00, 32'h00100513, 32'h04, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h00, 32'h00100513, 32'h08, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h00, 32'h00100513, 32'h08, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h00, 32'h00100513, 32'h08, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h04, 32'h00200593, 32'h0C, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h08, 32'h00300613, 32'h10, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h0C, 32'h00B50733, 32'h14, 0));
    // redirect to 0x40 with a full FIFO
    tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 32'h00, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 32'h00, 0));
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 32'h00, 32'h00100513, 32'h04, 0));
    tbl.push_back(v(0, 1, 0, 1, 32'h40, 1, 32'h00, 32'h00100513, 32'h08, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 32'h40, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h40, 32'h43424140, 32'h44, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 32'h44, 32'h47464544, 32'h48, 0));
    // misaligned redirect halts; later redirects ignored; reset clears
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 0, 32'h00, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 32'h00, 0));
    tbl.push_back(v(0, 1, 1, 1, 32'h42, 1, 32'h00, 32'h00100513, 32'h04, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 32'h04, 1));
    tbl.push_back(v(0, 1, 1, 1, 32'h80, 0, 0, 0, 32'h04, 1));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 32'h04, 1));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 0, 32'h00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      else @(negedge clk);
      fetch_en       = tbl[i].fe;
      bus.out_ready  = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      #1;
      chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d rom_addr", i), bus.rom_addr, tbl[i].eaddr);
      chk($sformatf("vec%0d fetch_err", i), 32'(fetch_err), 32'(tbl[i].eerr));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d out_pc", i), bus.out_pc, tbl[i].epc);
        chk($sformatf("vec%0d out_instr", i), bus.out_instr, tbl[i].einstr);
      end
    end

    // sequential run to the end of the ROM window
    do_reset();
    fetch_en      = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 67; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k >= 2 && k <= 65) begin
        chk($sformatf("range k%0d out_valid", k), 32'(bus.out_valid), 32'd1);
        chk($sformatf("range k%0d out_pc", k), bus.out_pc, 32'(4 * (k - 2)));
        chk($sformatf("range k%0d out_instr", k), bus.out_instr, word_at(32'(4 * (k - 2))));
        chk($sformatf("range k%0d fetch_err", k), 32'(fetch_err), 32'd0);
      end
      if (k == 65) begin
        chk("range last word", bus.out_instr, 32'hFFFEFDFC);
        chk("range addr at limit", bus.rom_addr, 32'h100);
      end
      if (k >= 66) begin
        chk($sformatf("range k%0d fetch_err", k), 32'(fetch_err), 32'd1);
        chk($sformatf("range k%0d out_valid", k), 32'(bus.out_valid), 32'd0);
        chk($sformatf("range k%0d rom_addr", k), bus.rom_addr, 32'h100);
      end
    end

    // asynchronous reset in mid-stream
    do_reset();
    fetch_en      = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre-areset out_valid", 32'(bus.out_valid), 32'd1);
    chk("pre-areset out_instr", bus.out_instr, 32'h00100513);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset out_valid", 32'(bus.out_valid), 32'd0);
    chk("areset rom_addr", bus.rom_addr, 32'h0);
    chk("areset out_pc", bus.out_pc, 32'h0);
    chk("areset out_instr", bus.out_instr, 32'h0);
    chk("areset fetch_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    fetch_en      = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("restart out_valid", 32'(bus.out_valid), 32'd1);
    chk("restart out_pc", bus.out_pc, 32'h0);
    chk("restart out_instr", bus.out_instr, 32'h00100513);
    chk("restart rom_addr", bus.rom_addr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
